axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning AXI-Lite address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning AXI-Lite data width (32 only supported).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in cycles.
REQ-004 The block SHALL have the following ports, all synchronous to axil_clk:
- axil_clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1 / cmd_ready  out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W / cmd_wdata  in  32  command address and write data.
- rsp_valid  out  1 / rsp_ready  in  1  response handshake.
- rsp_rdata  out  32 / rsp_resp  out  2 / rsp_timeout  out  1  response payload.
- m_axil_awvalid/awaddr/awready, m_axil_wvalid/wdata/wstrb/wready, m_axil_bvalid/bresp/bready, m_axil_arvalid/araddr/arready, m_axil_rvalid/rdata/rresp/rready  AXI-Lite master, standard widths.

Function
REQ-005 The block SHALL allow exactly one outstanding transaction; states are IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-006 cmd_ready SHALL equal (state==IDLE); on accept, the block SHALL register addr and data and move to WR or RD_ADDR.
REQ-007 In WR, awvalid and wvalid SHALL assert in the cycle after accept, and each SHALL drop independently on its own handshake.
REQ-008 The block SHALL move to WR_RESP in the cycle after both the AW and W handshakes have completed, in either order or simultaneously.
REQ-009 wstrb SHALL be all ones; awaddr and araddr SHALL be stable while their valid is high.
REQ-010 In WR_RESP, bready SHALL be 1; on bvalid the block SHALL capture bresp into rsp_resp, set rsp_rdata to 0 and move to RSP.
REQ-011 In RD_ADDR, arvalid SHALL be 1; on arready the block SHALL move to RD_DATA, where rready=1.
REQ-012 In RD_DATA, on rvalid the block SHALL capture rdata and rresp and move to RSP.
REQ-013 In RSP, rsp_valid SHALL be 1 and the payload SHALL be held stable until rsp_ready; the block SHALL then return to IDLE.
REQ-014 A new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-015 Minimum latency from command accept to rsp_valid SHALL be 3 cycles for both writes and reads, given zero-wait slaves.
REQ-016 bready and rready SHALL never be asserted outside WR_RESP and RD_DATA respectively.

Reset
REQ-017 While rst is high, the state SHALL be IDLE.
REQ-018 While rst is high, all valid and ready outputs SHALL be 0, except cmd_ready, which SHALL be 1 after reset deassertion.
REQ-019 While rst is high, rsp_rdata, rsp_resp, rsp_timeout, awaddr, araddr and wdata SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction immediately, with no response generated.

Configuration
REQ-021 With AXIL_CMD_TIMEOUT_EN defined, a counter SHALL clear on command accept and count every cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
REQ-022 With AXIL_CMD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drop all AXI valids and readies and move to RSP.
REQ-023 The timeout response SHALL carry rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-024 Without AXIL_CMD_TIMEOUT_EN, there SHALL be no counter, rsp_timeout SHALL be tied 0, and the block SHALL wait indefinitely.

Structure
REQ-025 Package axil_cmd_pkg SHALL hold the state enum, the AXI resp constants (OKAY=0, SLVERR=2) and the default TIMEOUT_CYCLES.
REQ-026 The watchdog counter SHALL be sub-module axil_cmd_wdog, instantiated only under AXIL_CMD_TIMEOUT_EN.

Verification
REQ-027 Write addr 0x0, data 0x100, zero-wait slave, bresp 0 -> awvalid and wvalid high cycle 1, bready cycle 2, rsp_valid cycle 3 with resp 0.
REQ-028 Write addr 0x4, data 0x80, with wready 3 cycles after awready -> wvalid held until wready, exactly one AW and one W beat, response OKAY.
REQ-029 Read addr 0x8, slave returns 0xaa00 -> rsp_rdata=0xaa00, rsp_resp=0, and rready high for exactly one cycle.
REQ-030 rsp_ready held low for 5 cycles -> rsp payload stable throughout and cmd_ready low until the cycle after the handshake.
REQ-031 With AXIL_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, a slave that never asserts arready -> arvalid drops after 16 cycles, rsp_resp=2, rsp_timeout=1.
REQ-032 rst pulsed while awvalid is high -> all valids 0 immediately, no rsp_valid, and the next command is accepted normally.

Source files
------------

// File: rtl/axil_cmd_pkg.sv
// axil_cmd_master shared types: FSM states, AXI response codes,
// default watchdog limit.
package axil_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axil_cmd_wdog.sv
// Watchdog counter for axil_cmd_master; hit fires on the last
// allowed busy cycle so the FSM leaves on the following edge.
module axil_cmd_wdog
  import axil_cmd_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign hit = busy && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding command to AXI-Lite master bridge.
// Optional watchdog enabled with `define AXIL_CMD_TIMEOUT_EN.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                axil_clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                m_axil_awvalid,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  input  logic                m_axil_awready,
  output logic                m_axil_wvalid,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  input  logic                m_axil_wready,
  input  logic                m_axil_bvalid,
  input  logic [1:0]          m_axil_bresp,
  output logic                m_axil_bready,
  output logic                m_axil_arvalid,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  input  logic                m_axil_arready,
  input  logic                m_axil_rvalid,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  output logic                m_axil_rready
);

  state_t state;
  logic   accept;
  logic   aw_done;
  logic   w_done;

  assign cmd_ready    = (state == S_IDLE) && !rst;
  assign accept       = cmd_valid && cmd_ready;
  assign m_axil_wstrb = '1;

  // a channel counts as done once its valid has dropped or is handshaking now
  assign aw_done = !m_axil_awvalid || m_axil_awready;
  assign w_done  = !m_axil_wvalid || m_axil_wready;

`ifdef AXIL_CMD_TIMEOUT_EN
  logic busy;
  logic tmo_hit;
  logic tmo_q;

  assign busy = state inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA};
  assign rsp_timeout = tmo_q;

  axil_cmd_wdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk  (axil_clk),
    .rst  (rst),
    .clear(accept),
    .busy (busy),
    .hit  (tmo_hit)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge axil_clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_araddr  <= '0;
      m_axil_wdata   <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= RESP_OKAY;
`ifdef AXIL_CMD_TIMEOUT_EN
      tmo_q          <= 1'b0;
`endif
    end else begin
`ifdef AXIL_CMD_TIMEOUT_EN
      if (tmo_hit) begin
        m_axil_awvalid <= 1'b0;
        m_axil_wvalid  <= 1'b0;
        m_axil_bready  <= 1'b0;
        m_axil_arvalid <= 1'b0;
        m_axil_rready  <= 1'b0;
        rsp_valid      <= 1'b1;
        rsp_rdata      <= '0;
        rsp_resp       <= RESP_SLVERR;
        tmo_q          <= 1'b1;
        state          <= S_RSP;
      end else
`endif
      unique case (state)
        S_IDLE: begin
          if (accept) begin
`ifdef AXIL_CMD_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            if (cmd_write) begin
              m_axil_awaddr  <= cmd_addr;
              m_axil_wdata   <= cmd_wdata;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= S_WR;
            end else begin
              m_axil_araddr  <= cmd_addr;
              m_axil_arvalid <= 1'b1;
              state          <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            m_axil_bready <= 1'b1;
            state         <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= m_axil_bresp;
            rsp_valid     <= 1'b1;
            state         <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            rsp_valid     <= 1'b1;
            state         <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: delay-programmable AXI-Lite
// slave plus a latency/response model built from the protocol rules.
module tb_axil_cmd_master;

  localparam int TMO = 16;

  logic        axil_clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;

  axil_cmd_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .axil_clk(axil_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
    .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wready(wready),
    .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
    .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_arready(arready),
    .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rready(rready)
  );

  initial begin
    axil_clk = 1'b0;
    forever #5 axil_clk = ~axil_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] rule(input logic [31:0] a);
    return (a[5:2] == 4'hf) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] deflt(input logic [31:0] a);
    return {a[15:0], 16'hc0de};
  endfunction

  // slave delay knobs: cycles of valid before ready / before response
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_age = 0, w_age = 0, b_age = 0, ar_age = 0, r_age = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, r_hi = 0;
  logic [31:0] last_aw = '0, last_w = '0, last_ar = '0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  always @(posedge axil_clk) begin
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    if (bready) b_hi++;
    if (arvalid) ar_hi++;
    if (rready) r_hi++;
    if (awvalid && awready) begin aw_n++; last_aw = awaddr; end
    if (wvalid && wready) begin w_n++; last_w = wdata; end
    if (bvalid && bready) b_n++;
    if (arvalid && arready) begin ar_n++; last_ar = araddr; end
    if (rvalid && rready) r_n++;
  end

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge axil_clk);
      if (awvalid) begin awready = (aw_age >= aw_dly); aw_age++; end
      else begin awready = 0; aw_age = 0; end
      if (wvalid) begin wready = (w_age >= w_dly); w_age++; end
      else begin wready = 0; w_age = 0; end
      if (arvalid) begin arready = (ar_age >= ar_dly); ar_age++; end
      else begin arready = 0; ar_age = 0; end
      if (aw_n > b_n && w_n > b_n) begin
        if (!bvalid) begin
          if (b_age >= b_dly) begin
            bvalid = 1; bresp = rule(last_aw);
            slave_mem[last_aw] = last_w;
          end else b_age++;
        end
      end else begin bvalid = 0; b_age = 0; end
      if (ar_n > r_n) begin
        if (!rvalid) begin
          if (r_age >= r_dly) begin
            rvalid = 1; rresp = rule(last_ar);
            rdata = slave_mem.exists(last_ar) ? slave_mem[last_ar]
                                              : deflt(last_ar);
          end else r_age++;
        end
      end else begin rvalid = 0; r_age = 0; rdata = 0; end
    end
  end

  task automatic run_cmd(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int hold);
    int nom, lat, n, bad, bad2;
    bit e_tmo, c1, c2;
    logic [31:0] e_data;
    logic [1:0] e_resp;
    longint e_hi, e_beats, g_hi, g_beats;
    int s_aw, s_w, s_b, s_ar, s_r, h_aw, h_w, h_b, h_ar, h_r;
    e_tmo = 0;
    e_resp = rule(a);
    if (wr) begin
      nom = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      e_data = '0;
      model_mem[a] = d;
      e_hi = (longint'(aw_dly + 1) << 32) | (longint'(w_dly + 1) << 24)
           | (longint'(b_dly + 1) << 16);
      e_beats = 64'h11100;
    end else begin
      nom = 3 + ar_dly + r_dly;
      e_data = model_mem.exists(a) ? model_mem[a] : deflt(a);
      e_hi = (longint'(ar_dly + 1) << 8) | longint'(r_dly + 1);
      e_beats = 64'h00011;
    end
`ifdef AXIL_CMD_TIMEOUT_EN
    if (nom > TMO) begin
      nom = TMO + 1; e_data = '0; e_resp = 2'b10; e_tmo = 1;
      e_hi = wr ? 64'h0 : (longint'(TMO) << 8);
      e_beats = 64'h0;
    end
`endif
    s_aw = aw_n; s_w = w_n; s_b = b_n; s_ar = ar_n; s_r = r_n;
    h_aw = aw_hi; h_w = w_hi; h_b = b_hi; h_ar = ar_hi; h_r = r_hi;
    @(negedge axil_clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge axil_clk); n++; end
    chk("cmd_ready", cmd_ready, 1);
    @(posedge axil_clk);
    #1 cmd_valid = 0;
    lat = 0; bad = 0; c1 = 0; c2 = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge axil_clk);
      lat++;
      if (lat == 1) c1 = wr ? (awvalid && wvalid) : arvalid;
      if (lat == 2) c2 = wr ? bready : rready;
      if (awvalid && awaddr !== a) bad++;
      if (wvalid && (wdata !== d || wstrb !== 4'hf)) bad++;
      if (arvalid && araddr !== a) bad++;
      if (bready && rready) bad++;
    end
    chk("latency", lat, nom);
    chk("valid_cyc1", c1, 1);
    if (nom == 3) chk("ready_cyc2", c2, 1);
    chk("addr_stable", bad, 0);
    chk("rsp_rdata", rsp_rdata, e_data);
    chk("rsp_resp", rsp_resp, e_resp);
    chk("rsp_timeout", rsp_timeout, e_tmo);
    bad2 = 0;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge axil_clk);
      if (!rsp_valid || rsp_rdata !== e_data || rsp_resp !== e_resp ||
          rsp_timeout !== e_tmo || cmd_ready) bad2++;
    end
    chk("rsp_hold", bad2, 0);
    rsp_ready = 1;
    @(posedge axil_clk);
    #1 rsp_ready = 0;
    @(negedge axil_clk);
    chk("idle_after",
        {rsp_valid, cmd_ready, awvalid, wvalid, arvalid, bready, rready},
        7'b0100000);
    g_hi = (longint'(aw_hi - h_aw) << 32) | (longint'(w_hi - h_w) << 24)
         | (longint'(b_hi - h_b) << 16) | (longint'(ar_hi - h_ar) << 8)
         | longint'(r_hi - h_r);
    g_beats = (longint'(aw_n - s_aw) << 16) | (longint'(w_n - s_w) << 12)
            | (longint'(b_n - s_b) << 8) | (longint'(ar_n - s_ar) << 4)
            | longint'(r_n - s_r);
    chk("valid_cycles", g_hi, e_hi);
    chk("beats", g_beats, e_beats);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0;
    repeat (3) @(negedge axil_clk);
    chk("rst_ready", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid,
                      bready, rready}, 7'b0);
    chk("rst_payload", {rsp_rdata, rsp_resp, rsp_timeout}, 35'b0);
    chk("rst_axi", {awaddr, araddr}, 64'b0);
    chk("rst_wdata", wdata, 32'b0);
    rst = 0;
    @(negedge axil_clk);
    chk("cmd_ready_out", cmd_ready, 1);

    run_cmd(1, 32'h0, 32'h100, 0);
    w_dly = 3;
    run_cmd(1, 32'h4, 32'h80, 0);
    w_dly = 0;
    slave_mem[32'h8] = 32'haa00;
    model_mem[32'h8] = 32'haa00;
    run_cmd(0, 32'h8, 32'h0, 0);
    run_cmd(0, 32'h8, 32'h0, 5);
    run_cmd(1, 32'h3c, 32'hdead, 2);

    // reset while the write address is still waiting for awready
    aw_dly = 30; w_dly = 30;
    @(negedge axil_clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h55;
    @(posedge axil_clk);
    #1 cmd_valid = 0;
    @(negedge axil_clk);
    @(negedge axil_clk);
    chk("pre_rst_aw", {awvalid, wvalid}, 2'b11);
    rst = 1;
    #1;
    chk("rst_abort", {awvalid, wvalid, arvalid, bready, rready, rsp_valid},
        6'b0);
    chk("rst_abort_regs", {awaddr, wdata}, 64'b0);
    @(negedge axil_clk);
    rst = 0;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    aw_dly = 0; w_dly = 0;
    repeat (3) @(negedge axil_clk);
    chk("post_rst", {rsp_valid, cmd_ready, awvalid}, 3'b010);
    run_cmd(1, 32'h10, 32'h77, 1);
    run_cmd(0, 32'h10, 32'h0, 0);

`ifdef AXIL_CMD_TIMEOUT_EN
    ar_dly = 1000;
    run_cmd(0, 32'h20, 32'h0, 1);
    ar_dly = 0;
    run_cmd(0, 32'h10, 32'h0, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      ra = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      run_cmd(1'($urandom_range(0, 1)), ra, $urandom,
              $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
